// File: rtl/countup_timer_if.sv
// Command/status bundle for the count-up second timer.
// master drives the commands and limit; slave is the timer.
interface countup_timer_if;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned TENS_W = 3;
  localparam int unsigned ONES_W = 4;

  logic              start;
  logic              stop;
  logic              clear;
  logic [SEC_W-1:0]  limit;
  logic [SEC_W-1:0]  count;
  logic [TENS_W-1:0] bcd_tens;
  logic [ONES_W-1:0] bcd_ones;
  logic              running;
  logic              expired;
  logic              sec_tick;

  modport master (
    output start, stop, clear, limit,
    input  count, bcd_tens, bcd_ones, running, expired, sec_tick
  );

  modport slave (
    input  start, stop, clear, limit,
    output count, bcd_tens, bcd_ones, running, expired, sec_tick
  );
endinterface

// File: rtl/countup_timer.sv
// Elapsed-seconds counter with binary and BCD views, a per-second tick pulse,
// and a sticky expired flag once the count reaches a live-sampled limit.
module countup_timer #(
  parameter int unsigned CYCLES_PER_SECOND = 100_000_000,
  parameter int unsigned CYC_W             = 27
) (
  input  logic            clk,
  input  logic            reset,
  countup_timer_if.slave  bus
);

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned TENS_W = 3;
  localparam int unsigned ONES_W = 4;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_SECOND - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [SEC_W-1:0]   count_q, count_d;
  logic [TENS_W-1:0]  tens_q, tens_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic               tick_q, tick_d;
  logic               running_q;
  logic               expired_q;
  logic [SEC_W:0]     count_inc;

  assign count_inc = {1'b0, count_q} + (SEC_W+1)'(1);

  // State and datapath registers; flags are decoded from the next state so
  // they land in the same edge as the transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      count_q   <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      count_q   <= count_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      tick_q    <= tick_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
    end
  end

  // Command priority: clear, then an honoured start, then stop, then counting.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    count_d = count_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    tick_d  = 1'b0;

    if (bus.clear) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
      count_d = '0;
      tens_d  = '0;
      ones_d  = '0;
    end else if (bus.start && (state_q == ST_IDLE)) begin
      cyc_d = '0;
      if (count_q >= bus.limit) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_RUN;
      end
    end else if (bus.stop && (state_q == ST_RUN)) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_RUN) begin
      if (cyc_q < CYC_LAST) begin
        cyc_d = cyc_q + CYC_W'(1);
      end else begin
        cyc_d   = '0;
        count_d = count_inc[SEC_W-1:0];
        tick_d  = 1'b1;
        if (ones_q == ONES_W'(9)) begin
          ones_d = '0;
          tens_d = tens_q + TENS_W'(1);
        end else begin
          ones_d = ones_q + ONES_W'(1);
        end
        // A running count stays below the limit, so this also caps it at 63.
        if (count_inc >= {1'b0, bus.limit}) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
  assign bus.running  = running_q;
  assign bus.expired  = expired_q;
  assign bus.sec_tick = tick_q;

endmodule

// File: tb/tb_countup_timer.sv
// Self-checking bench for countup_timer with a tick scoreboard.
module tb_countup_timer;

  localparam int unsigned CPS = 10;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc_n = 0;
  int   checks = 0;
  int   failures = 0;
  int   m_count = 0;
  exp_t sb[$];
  exp_t e;

  countup_timer_if bus ();

  countup_timer #(.CYCLES_PER_SECOND(CPS), .CYC_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: BCD invariant every cycle and tick scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((int'(bus.bcd_tens) !== int'(bus.count) / 10) || (int'(bus.bcd_ones) !== int'(bus.count) % 10)) begin
        failures++;
        $display("FAIL bcd_invariant: count=%0d tens=%0d ones=%0d", bus.count, bus.bcd_tens, bus.bcd_ones);
      end
      if (bus.sec_tick === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_tick: got tick at cycle %0d count=%0d, expected none", cyc_n, bus.count);
        end else begin
          e = sb.pop_front();
          if ((cyc_n !== e.cyc) || (int'(bus.count) !== e.cnt)) begin
            failures++;
            $display("FAIL tick: got cycle=%0d count=%0d, expected cycle=%0d count=%0d", cyc_n, bus.count, e.cyc, e.cnt);
          end
        end
      end
    end
  end

  task automatic do_start(input int n);
    int c;
    @(negedge clk);
    bus.start = 1'b1;
    c = cyc_n;
    for (int i = 1; i <= n; i++) sb.push_back('{cyc: c + 1 + int'(CPS) * i, cnt: m_count + i});
    m_count += n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    sb.delete();
    m_count = 0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.limit = 6'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.count, bus.bcd_tens, bus.bcd_ones, bus.running, bus.expired, bus.sec_tick} !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: got count=%0d run=%0b exp=%0b tick=%0b, expected all 0", bus.count, bus.running, bus.expired, bus.sec_tick);
    end
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd0) || (bus.running !== 1'b0)) begin
      failures++;
      $display("FAIL idle_after_reset: got count=%0d run=%0b, expected 0/0", bus.count, bus.running);
    end
  endtask

  task automatic test_basic();
    bus.limit = 6'd3;
    do_clear();
    do_start(3);
    checks++;
    if (bus.running !== 1'b1) begin
      failures++; $display("FAIL basic_running: got %0b expected 1", bus.running);
    end
    repeat (34) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd3) || (bus.expired !== 1'b1) || (bus.running !== 1'b0)) begin
      failures++;
      $display("FAIL basic_expire: got count=%0d exp=%0b run=%0b, expected 3/1/0", bus.count, bus.expired, bus.running);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.count !== 6'd3) begin
      failures++; $display("FAIL basic_hold: got count=%0d expected 3", bus.count);
    end
  endtask

  task automatic test_pause();
    bus.limit = 6'd20;
    do_clear();
    do_start(9);
    repeat (90) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd9) || (bus.bcd_ones !== 4'd9)) begin
      failures++; $display("FAIL pause_pre: got count=%0d ones=%0d expected 9/9", bus.count, bus.bcd_ones);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd9) || (bus.running !== 1'b0)) begin
      failures++; $display("FAIL pause_hold: got count=%0d run=%0b expected 9/0", bus.count, bus.running);
    end
    do_start(11);
    repeat (10) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd10) || (bus.bcd_tens !== 3'd1) || (bus.bcd_ones !== 4'd0)) begin
      failures++;
      $display("FAIL pause_resume: got count=%0d tens=%0d ones=%0d expected 10/1/0", bus.count, bus.bcd_tens, bus.bcd_ones);
    end
    repeat (105) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd20) || (bus.expired !== 1'b1) || (bus.bcd_tens !== 3'd2)) begin
      failures++; $display("FAIL pause_expire: got count=%0d exp=%0b expected 20/1", bus.count, bus.expired);
    end
  endtask

  task automatic test_limit_zero();
    bus.limit = 6'd0;
    do_clear();
    do_start(0);
    checks++;
    if ((bus.expired !== 1'b1) || (bus.running !== 1'b0) || (bus.count !== 6'd0) || (bus.sec_tick !== 1'b0)) begin
      failures++;
      $display("FAIL limit0_start: got exp=%0b run=%0b count=%0d tick=%0b expected 1/0/0/0", bus.expired, bus.running, bus.count, bus.sec_tick);
    end
    do_start(0);
    repeat (12) @(negedge clk);
    checks++;
    if ((bus.expired !== 1'b1) || (bus.running !== 1'b0) || (bus.count !== 6'd0)) begin
      failures++; $display("FAIL limit0_restart: got exp=%0b run=%0b count=%0d expected 1/0/0", bus.expired, bus.running, bus.count);
    end
    do_clear();
    checks++;
    if (bus.expired !== 1'b0) begin
      failures++; $display("FAIL limit0_clear: got exp=%0b expected 0", bus.expired);
    end
  endtask

  task automatic test_limit_max();
    bus.limit = 6'd63;
    do_clear();
    do_start(63);
    repeat (635) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd63) || (bus.bcd_tens !== 3'd6) || (bus.bcd_ones !== 4'd3) || (bus.expired !== 1'b1) || (bus.running !== 1'b0)) begin
      failures++;
      $display("FAIL max_expire: got count=%0d tens=%0d ones=%0d exp=%0b run=%0b expected 63/6/3/1/0", bus.count, bus.bcd_tens, bus.bcd_ones, bus.expired, bus.running);
    end
    do_start(0);
    repeat (20) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd63) || (bus.running !== 1'b0)) begin
      failures++; $display("FAIL max_nowrap: got count=%0d run=%0b expected 63/0", bus.count, bus.running);
    end
    do_clear();
  endtask

  task automatic test_back_to_back();
    bus.limit = 6'd20;
    do_clear();
    do_start(5);
    repeat (50) @(negedge clk);
    checks++;
    if (bus.count !== 6'd5) begin
      failures++; $display("FAIL b2b_pre: got count=%0d expected 5", bus.count);
    end
    bus.clear = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0; bus.start = 1'b0;
    sb.delete(); m_count = 0;
    checks++;
    if ((bus.count !== 6'd0) || (bus.running !== 1'b0) || (bus.expired !== 1'b0)) begin
      failures++; $display("FAIL clear_start: got count=%0d run=%0b exp=%0b expected 0/0/0", bus.count, bus.running, bus.expired);
    end
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++;
    if (bus.running !== 1'b1) begin
      failures++; $display("FAIL start_stop: got run=%0b expected 1", bus.running);
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    bus.limit = 6'd20;
    do_clear();
    do_start(7);
    repeat (74) @(negedge clk);
    checks++;
    if (bus.count !== 6'd7) begin
      failures++; $display("FAIL areset_pre: got count=%0d expected 7", bus.count);
    end
    #2 reset = 1'b0;
    sb.delete(); m_count = 0;
    #1;
    checks++;
    if ({bus.count, bus.bcd_tens, bus.bcd_ones, bus.running, bus.expired, bus.sec_tick} !== 16'd0) begin
      failures++;
      $display("FAIL areset_immediate: got count=%0d run=%0b exp=%0b, expected all 0", bus.count, bus.running, bus.expired);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if ((bus.count !== 6'd0) || (bus.running !== 1'b0)) begin
      failures++; $display("FAIL areset_idle: got count=%0d run=%0b expected 0/0", bus.count, bus.running);
    end
    do_start(1);
    repeat (10) @(negedge clk);
    checks++;
    if (bus.count !== 6'd1) begin
      failures++; $display("FAIL areset_restart: got count=%0d expected 1", bus.count);
    end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_limit_zero();
    test_limit_max();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL missing_ticks: got %0d pending, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countup_timer.md
Name: countup_timer

Overview:
- Elapsed-time (count-up) second counter: the counting-up partner of the game's countdown timer.
- Counts whole seconds from 0 up to a programmable limit, then raises `expired`.
- Provides binary and BCD (tens/ones) views of the count for the score/time display path.
- Emits a one-cycle pulse on each second boundary for game logic such as mole spawn pacing.

Parameters:
- CYCLES_PER_SECOND, 100_000_000: clk cycles per counted second. Must be ≥2. Sims use 10.
- CYC_W, 27: width of the internal cycle counter. Must satisfy 2^CYC_W ≥ CYCLES_PER_SECOND.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start or resume counting (level, sampled each cycle).
- stop  in  1  pause counting.
- clear  in  1  synchronous clear of count and flags.
- limit  in  6  terminal second value, 0–63.
- count  out  6  elapsed seconds, binary.
- bcd_tens  out  3  tens digit of count, 0–6.
- bcd_ones  out  4  ones digit of count, 0–9.
- running  out  1  counter is actively advancing.
- expired  out  1  count has reached limit; sticky until clear or reset.
- sec_tick  out  1  one-cycle pulse in the cycle count increments.

Behaviour:
- Reset (reset=0, asynchronous): count=0, bcd_tens=0, bcd_ones=0, running=0, expired=0, sec_tick=0, cycle counter=0. All outputs are registered.
- Command priority per cycle: clear > start > stop > counting.
- clear:
  - count, BCD digits and cycle counter go to 0; running=0; expired=0; sec_tick=0.
  - clear while running also stops.
- start, honoured only when running=0 and expired=0:
  - cycle counter=0; count is retained (resume semantics).
  - If count ≥ limit: expired=1, running stays 0. This covers limit=0.
  - Otherwise running=1.
  - start while running or while expired is ignored.
- stop: running=0. Count and cycle counter hold. A later start zeroes the cycle counter, so a partial second is discarded.
- Counting, when running=1 and no command is active:
  - If cycle counter < CYCLES_PER_SECOND-1: increment it.
  - Otherwise, in a single registered update:
    - cycle counter=0, count=count+1, sec_tick=1.
    - BCD: if ones=9 then ones=0 and tens=tens+1, else ones=ones+1.
    - If count+1 ≥ limit: expired=1 and running=0 in the same update.
- sec_tick is 1 for exactly one cycle per increment and 0 otherwise, including during pause, clear and expiry holds.
- First increment occurs CYCLES_PER_SECOND cycles after the cycle in which start is sampled.
- Limit changes:
  - limit is sampled live.
  - Lowering limit to ≤ count while running takes effect at the next second boundary: count increments once more, then expired=1.
  - Raising limit while expired has no effect until clear.
- count never wraps. The maximum reachable value is 63 with limit=63, which expires at 63.
- BCD digits always equal count/10 and count%10. This is an invariant checked every cycle.
- start and stop asserted together: start wins when honoured. If start is ignored, stop applies.
- Reset asserted mid-count: all outputs return to reset values immediately, without waiting for a clk edge.

Test Plan:
- CYCLES_PER_SECOND=10, limit=3, pulse start at cycle 0 → sec_tick at cycles 10, 20, 30; count 1, 2, 3; expired=1 and running=0 after cycle 30; count stays 3.
- limit=20, run to count=9, stop 5 cycles, start → no increment while paused; next increment 10 cycles after restart; count=10 with bcd_tens=1, bcd_ones=0.
- limit=0, start → expired=1 next cycle, running=0, count=0, no sec_tick. Second start ignored; clear then expired=0.
- limit=63, run to end → count reaches 63 (tens=6, ones=3), expired=1, no wrap. Further start ignored until clear.
- clear and start asserted the same cycle while running at count=5 → count=0, running=0, expired=0. Also assert start and stop together from idle → running=1.
- Drop reset to 0 asynchronously mid-second at count=7 → outputs reach reset values before the next clk edge. After release, counting resumes only on a new start.
